// File: rtl/alu_op_sequencer_if.sv
// Bundle of the command stream, alu launch/result wires and response stream
// that the FP8 op sequencer sits on. The sequencer is the master side.
interface alu_op_sequencer_if;
  // command stream
  logic       cmd_valid;
  logic       cmd_ready;
  logic [3:0] cmd_op;
  logic [7:0] cmd_a;
  logic [7:0] cmd_b;
  // alu side
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [3:0] alu_ctrl;
  logic       alu_start;
  logic [7:0] alu_y;
  logic       alu_valid;
  // response stream
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_y;
  logic       rsp_timeout;
  logic [7:0] ops_done;

  modport master (
    input  cmd_valid, cmd_op, cmd_a, cmd_b, alu_y, alu_valid, rsp_ready,
    output cmd_ready, alu_a, alu_b, alu_ctrl, alu_start,
           rsp_valid, rsp_y, rsp_timeout, ops_done
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_a, cmd_b, alu_y, alu_valid, rsp_ready,
    input  cmd_ready, alu_a, alu_b, alu_ctrl, alu_start,
           rsp_valid, rsp_y, rsp_timeout, ops_done
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// Initiator for the FP8 (E4M3) alu start/valid protocol. Accepts one command,
// pulses the alu reset as a start strobe, waits for is_output_valid (or gives
// up after a bounded wait) and returns the result on a response stream.
module alu_op_sequencer #(
  parameter int START_CYCLES   = 1,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  alu_op_sequencer_if.master   bus
);

  localparam int SCW = $clog2(START_CYCLES + 1);
  localparam int WCW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [SCW-1:0] START_LOAD = SCW'(START_CYCLES - 1);
  localparam logic [WCW-1:0] WAIT_LAST  = WCW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t          state;
  state_t          state_next;
  logic [SCW-1:0]  start_cnt;
  logic [WCW-1:0]  wait_cnt;
  logic            accept;
  logic            start_last;
  logic            wait_expire;
  logic            rsp_done;

  // Wait counter increment that parks at all-ones instead of wrapping.
  function automatic logic [WCW-1:0] sat_inc(input logic [WCW-1:0] v);
    return (v == {WCW{1'b1}}) ? v : v + WCW'(1);
  endfunction

  // Handshake and counter terminal conditions.
  always_comb begin
    accept      = (state == IDLE) && bus.cmd_ready && bus.cmd_valid;
    start_last  = (state == START) && (start_cnt == '0);
    wait_expire = (wait_cnt >= WAIT_LAST);
    rsp_done    = (state == RESP) && bus.rsp_ready;
  end

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state decode: one op in flight at a time, strictly IDLE->START->WAIT->RESP.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (accept)                            state_next = START;
      START: if (start_last)                        state_next = WAIT;
      WAIT:  if (bus.alu_valid || wait_expire)      state_next = RESP;
      RESP:  if (rsp_done)                          state_next = IDLE;
      default:                                      state_next = IDLE;
    endcase
  end

  // Control outputs and counters; alu_start idles high under reset to hold the alu cleared.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      bus.cmd_ready <= 1'b0;
      bus.alu_start <= 1'b1;
      start_cnt     <= '0;
      wait_cnt      <= '0;
      bus.rsp_valid <= 1'b0;
      bus.ops_done  <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            bus.cmd_ready <= 1'b0;
            bus.alu_start <= 1'b1;
            start_cnt     <= START_LOAD;
          end else begin
            bus.cmd_ready <= 1'b1;
            bus.alu_start <= 1'b0;
          end
        end
        START: begin
          if (start_last) begin
            bus.alu_start <= 1'b0;
            wait_cnt      <= '0;
          end else begin
            start_cnt <= start_cnt - SCW'(1);
          end
        end
        WAIT: begin
          // A valid seen on the expiring edge still wins over the timeout.
          if (bus.alu_valid || wait_expire) bus.rsp_valid <= 1'b1;
          else                              wait_cnt      <= sat_inc(wait_cnt);
        end
        RESP: begin
          if (bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
            bus.ops_done  <= bus.ops_done + 8'd1;
            bus.cmd_ready <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Operand and result registers; operands hold from accept to the next accept.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      bus.alu_a       <= 8'h00;
      bus.alu_b       <= 8'h00;
      bus.alu_ctrl    <= 4'h0;
      bus.rsp_y       <= 8'h00;
      bus.rsp_timeout <= 1'b0;
    end else begin
      if (accept) begin
        bus.alu_a    <= bus.cmd_a;
        bus.alu_b    <= bus.cmd_b;
        bus.alu_ctrl <= bus.cmd_op;
      end
      if (state == WAIT) begin
        if (bus.alu_valid) begin
          bus.rsp_y       <= bus.alu_y;
          bus.rsp_timeout <= 1'b0;
        end else if (wait_expire) begin
          bus.rsp_y       <= 8'h00;
          bus.rsp_timeout <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: FP8 alu model with programmable latency,
// transaction-level reference model, per-cycle compare and directed scenarios.
module tb_alu_op_sequencer;
  localparam int S = 1;
  localparam int T = 16;

  logic clock = 1'b0;
  logic reset = 1'b1;
  alu_op_sequencer_if bus();

  alu_op_sequencer #(.START_CYCLES(S), .TIMEOUT_CYCLES(T)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- FP8 E4M3 value arithmetic ----------------
  function automatic real dec(input logic [7:0] v);
    real r;
    int  e;
    e = int'(v[6:3]);
    r = (e == 0) ? real'(v[2:0]) / 8.0 : 1.0 + real'(v[2:0]) / 8.0;
    if (e == 0) e = 1;
    for (int i = 0; i < e - 7; i++) r = r * 2.0;
    for (int i = 0; i < 7 - e; i++) r = r / 2.0;
    return v[7] ? -r : r;
  endfunction

  function automatic logic [7:0] enc(input real x);
    real  ax;
    int   e;
    int   m;
    logic s;
    if (x == 0.0) return 8'h00;
    s  = (x < 0.0);
    ax = s ? -x : x;
    e  = 0;
    for (int i = 0; i < 64 && ax >= 2.0; i++) begin ax = ax / 2.0; e++; end
    for (int i = 0; i < 64 && ax < 1.0; i++)  begin ax = ax * 2.0; e--; end
    if (e + 7 < 1) return {s, 7'h00};
    m = int'((ax - 1.0) * 8.0);
    if (m == 8) begin m = 0; e++; end
    if (e + 7 > 15 || (e + 7 == 15 && m == 7)) return {s, 7'h7E};
    return {s, 4'(e + 7), 3'(m)};
  endfunction

  function automatic logic [7:0] fp8(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      4'b0001: return enc(dec(a) + dec(b));
      4'b0010: return enc(dec(a) * dec(b));
      default: return a ^ b;
    endcase
  endfunction

  // ---------------- alu model: valid alu_lat edges after start falls ----------------
  int         alu_lat = 0;   // 255 = never valid
  logic [7:0] alu_cnt;
  always @(posedge clock or negedge reset) begin
    if (!reset)              alu_cnt <= 8'd0;
    else if (bus.alu_start)  alu_cnt <= 8'd0;
    else if (alu_cnt != 8'hFF) alu_cnt <= alu_cnt + 8'd1;
  end
  assign bus.alu_valid = !bus.alu_start && (alu_lat < 255) && (int'(alu_cnt) >= alu_lat);
  assign bus.alu_y     = fp8(bus.alu_ctrl, bus.alu_a, bus.alu_b);

  // ---------------- reference model (transaction timing formulas) ----------------
  int         m_cyc = 0;
  int         m_acc = 0;
  int         m_rsp_at = 0;
  bit         m_busy = 0;
  bit         m_will_to = 0;
  logic       m_cmd_ready = 0, m_start = 1, m_rsp_valid = 0, m_to = 0;
  logic [7:0] m_y = 0, m_ops = 0, m_a = 0, m_b = 0;
  logic [3:0] m_ctrl = 0;

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_cmd_ready <= 1'b0;  m_start <= 1'b1;  m_busy <= 1'b0;
      m_rsp_valid <= 1'b0;  m_y <= 8'h00;     m_to <= 1'b0;
      m_ops <= 8'h00;       m_a <= 8'h00;     m_b <= 8'h00;  m_ctrl <= 4'h0;
    end else begin
      m_cyc <= m_cyc + 1;
      if (m_busy) begin
        if (m_cyc == m_acc + S) m_start <= 1'b0;
        if (m_cyc == m_rsp_at) begin
          m_busy      <= 1'b0;
          m_rsp_valid <= 1'b1;
          m_to        <= m_will_to;
          m_y         <= m_will_to ? 8'h00 : fp8(m_ctrl, m_a, m_b);
        end
      end else if (m_rsp_valid) begin
        if (bus.rsp_ready) begin
          m_rsp_valid <= 1'b0;
          m_ops       <= m_ops + 8'd1;
          m_cmd_ready <= 1'b1;
        end
      end else if (m_cmd_ready && bus.cmd_valid) begin
        m_a <= bus.cmd_a;  m_b <= bus.cmd_b;  m_ctrl <= bus.cmd_op;
        m_busy      <= 1'b1;
        m_acc       <= m_cyc;
        m_rsp_at    <= m_cyc + S + 1 + ((alu_lat > T - 1) ? T - 1 : alu_lat);
        m_will_to   <= (alu_lat > T - 1);
        m_start     <= 1'b1;
        m_cmd_ready <= 1'b0;
      end else begin
        m_cmd_ready <= 1'b1;
        m_start     <= 1'b0;
      end
    end
  end

  // Per-cycle compare against the model.
  always @(negedge clock) begin
    if (chk_en) begin
      chk("cmd_ready",   32'(bus.cmd_ready),   32'(m_cmd_ready));
      chk("alu_start",   32'(bus.alu_start),   32'(m_start));
      chk("alu_a",       32'(bus.alu_a),       32'(m_a));
      chk("alu_b",       32'(bus.alu_b),       32'(m_b));
      chk("alu_ctrl",    32'(bus.alu_ctrl),    32'(m_ctrl));
      chk("rsp_valid",   32'(bus.rsp_valid),   32'(m_rsp_valid));
      chk("rsp_y",       32'(bus.rsp_y),       32'(m_y));
      chk("rsp_timeout", 32'(bus.rsp_timeout), 32'(m_to));
      chk("ops_done",    32'(bus.ops_done),    32'(m_ops));
    end
  end

  // Handshake log and bookkeeping.
  logic [8:0] log_q[$];
  int         start_hi = 0;
  int         cyc = 0;
  int         acc_cyc = 0;
  always @(negedge clock) begin
    if (reset && bus.rsp_valid && bus.rsp_ready) log_q.push_back({bus.rsp_timeout, bus.rsp_y});
    if (reset && bus.alu_start) start_hi <= start_hi + 1;
  end
  always @(posedge clock) cyc <= cyc + 1;

  // ---------------- stimulus tasks (drive at posedge+1) ----------------
  task automatic send(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b, input int lat);
    bit got;
    got = 1'b0;
    bus.cmd_op = op; bus.cmd_a = a; bus.cmd_b = b; alu_lat = lat; bus.cmd_valid = 1'b1;
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge clock);
      got = bus.cmd_ready;
      @(posedge clock); #1;
    end
    if (!got) chk("accept_bound", 32'd0, 32'd1);
    acc_cyc = cyc;
  endtask

  task automatic wait_rsp(output logic [7:0] y, output logic to);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge clock);
      got = bus.rsp_valid;
      if (!got) begin @(posedge clock); #1; end
    end
    if (!got) chk("rsp_bound", 32'd0, 32'd1);
    y  = bus.rsp_y;
    to = bus.rsp_timeout;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] y, y0;
    logic       to, to0;
    logic [7:0] o0;
    int         s0, bp, nz;
    bus.cmd_valid = 1'b0; bus.cmd_op = 4'h0; bus.cmd_a = 8'h00; bus.cmd_b = 8'h00;
    bus.rsp_ready = 1'b1;

    // reset values
    #2 reset = 1'b0;
    chk_en = 1'b1;
    #1;
    chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd0);
    chk("rst_alu_start", 32'(bus.alu_start), 32'd1);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_ops_done",  32'(bus.ops_done),  32'd0);
    chk("rst_alu_a",     32'(bus.alu_a),     32'd0);
    @(negedge clock); #2 reset = 1'b1;
    @(posedge clock); #1;
    chk("rel_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    chk("rel_alu_start", 32'(bus.alu_start), 32'd0);

    // pin the FP8 model
    chk("fp8_add_2_2",   32'(fp8(4'b0001, 8'h40, 8'h40)), 32'h48);
    chk("fp8_mul_1_m1",  32'(fp8(4'b0010, 8'h38, 8'hB8)), 32'hB8);
    chk("fp8_mul_frac",  32'(fp8(4'b0010, 8'hAC, 8'hC0)), 32'h34);
    chk("fp8_mul_zero",  32'(fp8(4'b0010, 8'h00, 8'h00)), 32'h00);

    // 1: add
    s0 = start_hi;
    send(4'b0001, 8'h40, 8'h40, 1);
    bus.cmd_valid = 1'b0;
    wait_rsp(y, to);
    chk("t1_rsp_y", 32'(y), 32'h48);
    chk("t1_timeout", 32'(to), 32'd0);
    @(posedge clock); #1;
    chk("t1_ops_done", 32'(bus.ops_done), 32'd1);
    chk("t1_start_cycles", 32'(start_hi - s0), 32'(S));

    // 2: back-to-back muls, cmd_valid held
    log_q.delete();
    send(4'b0010, 8'h38, 8'hB8, 0);
    send(4'b0010, 8'hAC, 8'hC0, 0);
    bus.cmd_valid = 1'b0;
    for (int i = 0; i < 100 && log_q.size() < 2; i++) begin @(posedge clock); #1; end
    chk("t2_count", 32'(log_q.size()), 32'd2);
    if (log_q.size() >= 2) begin
      chk("t2_first",  32'(log_q[0]), 32'h0B8);
      chk("t2_second", 32'(log_q[1]), 32'h034);
    end

    // 3: backpressure for 6 cycles with a second command pending
    bus.rsp_ready = 1'b0;
    send(4'b0010, 8'h38, 8'h38, 0);
    bus.cmd_op = 4'b0001; bus.cmd_a = 8'h40; bus.cmd_b = 8'h38;
    wait_rsp(y0, to0);
    chk("t3_rsp_y", 32'(y0), 32'h38);
    o0 = bus.ops_done;
    for (int i = 0; i < 6; i++) begin
      @(posedge clock); #1;
      @(negedge clock);
      chk("t3_hold_valid", 32'(bus.rsp_valid), 32'd1);
      chk("t3_hold_y", 32'(bus.rsp_y), 32'(y0));
      chk("t3_hold_to", 32'(bus.rsp_timeout), 32'(to0));
      chk("t3_hold_cmd_ready", 32'(bus.cmd_ready), 32'd0);
    end
    @(posedge clock); #1;
    bus.rsp_ready = 1'b1;
    @(posedge clock); #1;
    chk("t3_ops_once", 32'(bus.ops_done), 32'(8'(o0 + 8'd1)));
    send(4'b0001, 8'h40, 8'h38, 0);
    bus.cmd_valid = 1'b0;
    wait_rsp(y, to);
    chk("t3_second_y", 32'(y), 32'h44);
    @(posedge clock); #1;
    chk("t3_ops_two", 32'(bus.ops_done), 32'(8'(o0 + 8'd2)));

    // 4: timeout
    send(4'b0001, 8'h40, 8'h40, 255);
    bus.cmd_valid = 1'b0;
    wait_rsp(y, to);
    chk("t4_latency", 32'(cyc - acc_cyc), 32'(S + T));
    chk("t4_rsp_y", 32'(y), 32'h00);
    chk("t4_timeout", 32'(to), 32'd1);
    @(posedge clock); #1;

    // 5: reset mid-WAIT
    send(4'b0001, 8'h40, 8'h40, 255);
    bus.cmd_valid = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    #1;
    chk("t5_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("t5_cmd_ready", 32'(bus.cmd_ready), 32'd0);
    chk("t5_alu_start", 32'(bus.alu_start), 32'd1);
    chk("t5_ops_done",  32'(bus.ops_done),  32'd0);
    @(negedge clock); #1 reset = 1'b1;
    @(posedge clock); #1;
    chk("t5_ready_after", 32'(bus.cmd_ready), 32'd1);

    // random ops, latencies across the timeout boundary, random backpressure
    for (int n = 0; n < 60; n++) begin
      int r;
      logic [3:0] op;
      r  = $urandom_range(0, 3);
      op = (r == 0) ? 4'b0001 : (r == 1) ? 4'b0010 : 4'($urandom_range(0, 15));
      bp = $urandom_range(0, 3);
      bus.rsp_ready = (bp == 0);
      send(op, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), $urandom_range(0, 18));
      bus.cmd_valid = 1'b0;
      wait_rsp(y, to);
      repeat (bp) begin @(posedge clock); #1; end
      bus.rsp_ready = 1'b1;
      @(posedge clock); #1;
      repeat ($urandom_range(0, 2)) begin @(posedge clock); #1; end
    end

    // 6: ops_done wrap
    reset = 1'b0;
    @(negedge clock); #1 reset = 1'b1;
    @(posedge clock); #1;
    log_q.delete();
    bus.rsp_ready = 1'b1;
    for (int n = 0; n < 256; n++) begin
      send(4'b0010, 8'h00, 8'h00, 0);
      bus.cmd_valid = 1'b0;
      wait_rsp(y, to);
      @(posedge clock); #1;
    end
    nz = 0;
    foreach (log_q[i]) if (log_q[i] != 9'h000) nz++;
    chk("t6_count", 32'(log_q.size()), 32'd256);
    chk("t6_nonzero", 32'(nz), 32'd0);
    chk("t6_ops_wrap", 32'(bus.ops_done), 32'd0);

    @(negedge clock);
    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
